// File: rtl/biquad8_coeff_loader.sv
// Serial coefficient loader for the biquad8 filter: stages host words locally, then shifts
// them into the filter's B-register cascade highest index first and optionally commits them.
module biquad8_coeff_loader #(
   parameter int unsigned NCOEFF      = 2,
   parameter int unsigned WR_GAP      = 1,
   parameter bit          AUTO_UPDATE = 1'b1,
   localparam int unsigned AdrW       = (NCOEFF > 1) ? $clog2(NCOEFF) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AdrW-1:0] stage_adr_i,
   input  logic [17:0]     stage_dat_i,
   input  logic            stage_wr_i,
   input  logic            load_i,
   input  logic            update_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [17:0]     coeff_dat_o,
   output logic            coeff_wr_o,
   output logic            coeff_update_o
);

   localparam int unsigned CntW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

   typedef enum logic [2:0] {StIdle, StShift, StGap, StSettle, StUpdate} state_e;

   state_e            state_q, state_d;
   logic [AdrW-1:0]   idx_q, idx_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [17:0]       dat_q, dat_d;
   logic              done_q, done_d;
   logic [17:0]       staging_q [NCOEFF];
   logic [17:0]       staging_d [NCOEFF];

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
         dat_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < int'(NCOEFF); i++) begin
            staging_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         dat_q   <= dat_d;
         done_q  <= done_d;
         for (int i = 0; i < int'(NCOEFF); i++) begin
            staging_q[i] <= staging_d[i];
         end
      end
   end

   // Staging writes are only honoured while idle
   always_comb begin
      for (int i = 0; i < int'(NCOEFF); i++) begin
         staging_d[i] = staging_q[i];
      end
      if (stage_wr_i && (state_q == StIdle) && (32'(stage_adr_i) < NCOEFF)) begin
         staging_d[stage_adr_i] = stage_dat_i;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load_i) begin
               state_d = StShift;
               idx_d   = AdrW'(NCOEFF - 1);
            end else if (update_i) begin
               state_d = StUpdate;
            end
         end
         StShift: begin
            if (idx_q == '0) begin
               state_d = StSettle;
               cnt_d   = CntW'(1);
            end else begin
               state_d = StGap;
               cnt_d   = CntW'(WR_GAP - 1);
            end
         end
         StGap: begin
            if (cnt_q == '0) begin
               state_d = StShift;
               idx_d   = idx_q - 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StSettle: begin
            if (cnt_q == '0) begin
               if (AUTO_UPDATE) begin
                  state_d = StUpdate;
               end else begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StUpdate: begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // Data is registered on entry to SHIFT so it holds through the following GAP/SETTLE cycle
   always_comb begin
      dat_d = dat_q;
      if (state_d == StShift) begin
         dat_d = staging_d[idx_d];
      end
   end

   // Outputs
   always_comb begin
      busy_o         = 1'b1;
      coeff_wr_o     = 1'b0;
      coeff_update_o = 1'b0;
      unique case (state_q)
         StIdle:   busy_o = 1'b0;
         StShift:  coeff_wr_o = 1'b1;
         StUpdate: coeff_update_o = 1'b1;
         default:  ;
      endcase
      done_o      = done_q;
      coeff_dat_o = dat_q;
   end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Self-checking bench: three loader configurations share one stimulus stream and are compared
// cycle by cycle against a timing model derived from the load/update sequencing rules.
module tb_biquad8_coeff_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  adr = '0;
   logic [17:0] sdat = '0;
   logic        swr = 1'b0;
   logic        load = 1'b0;
   logic        upd = 1'b0;

   logic        busy_w [3];
   logic        done_w [3];
   logic        wr_w   [3];
   logic        updo_w [3];
   logic [17:0] dat_w  [3];

   int checks = 0;
   int failures = 0;

   logic [17:0] mstg [3][16];
   logic [17:0] mdat [3];
   logic [21:0] cap  [3][21];

   always #5 clk = ~clk;

   biquad8_coeff_loader #(.NCOEFF(2), .WR_GAP(1), .AUTO_UPDATE(1'b1)) u0 (
      .clk(clk), .rst(rst), .stage_adr_i(adr[0:0]), .stage_dat_i(sdat), .stage_wr_i(swr),
      .load_i(load), .update_i(upd), .busy_o(busy_w[0]), .done_o(done_w[0]),
      .coeff_dat_o(dat_w[0]), .coeff_wr_o(wr_w[0]), .coeff_update_o(updo_w[0]));

   biquad8_coeff_loader #(.NCOEFF(4), .WR_GAP(3), .AUTO_UPDATE(1'b1)) u1 (
      .clk(clk), .rst(rst), .stage_adr_i(adr[1:0]), .stage_dat_i(sdat), .stage_wr_i(swr),
      .load_i(load), .update_i(upd), .busy_o(busy_w[1]), .done_o(done_w[1]),
      .coeff_dat_o(dat_w[1]), .coeff_wr_o(wr_w[1]), .coeff_update_o(updo_w[1]));

   biquad8_coeff_loader #(.NCOEFF(3), .WR_GAP(2), .AUTO_UPDATE(1'b0)) u2 (
      .clk(clk), .rst(rst), .stage_adr_i(adr[1:0]), .stage_dat_i(sdat), .stage_wr_i(swr),
      .load_i(load), .update_i(upd), .busy_o(busy_w[2]), .done_o(done_w[2]),
      .coeff_dat_o(dat_w[2]), .coeff_wr_o(wr_w[2]), .coeff_update_o(updo_w[2]));

   function automatic int pn(int i);
      return (i == 0) ? 2 : (i == 1) ? 4 : 3;
   endfunction
   function automatic int pg(int i);
      return (i == 0) ? 1 : (i == 1) ? 3 : 2;
   endfunction
   function automatic int pa(int i);
      return (i == 2) ? 0 : 1;
   endfunction
   function automatic int pmask(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   // Packed as {busy, done, wr, update, dat}
   function automatic logic [21:0] obs(int i);
      return {busy_w[i], done_w[i], wr_w[i], updo_w[i], dat_w[i]};
   endfunction

   // Expected outputs k cycles after the edge that sampled load_i
   function automatic logic [21:0] exp_load(int i, int k);
      int n, g, last, fin, jj, j;
      logic w, u;
      n    = pn(i);
      g    = pg(i);
      last = 1 + (n - 1) * (g + 1);
      fin  = (pa(i) == 1) ? last + 3 : last + 2;
      jj   = (k - 1) / (g + 1);
      w    = ((k - 1) % (g + 1) == 0) && (jj < n);
      j    = (jj < n) ? jj : n - 1;
      u    = (pa(i) == 1) && (k == last + 3);
      return {k <= fin, k == fin + 1, w, u, mstg[i][n - 1 - j]};
   endfunction

   function automatic logic [21:0] exp_upd(int i, int k);
      return {k == 1, k == 2, 1'b0, k == 1, mdat[i]};
   endfunction

   task automatic stage(input logic [3:0] a, input logic [17:0] d);
      int ea;
      swr = 1'b1; adr = a; sdat = d;
      @(negedge clk);
      swr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ea = int'(a) & pmask(i);
         if (ea < pn(i)) mstg[i][ea] = d;
      end
   endtask

   task automatic stage_random();
      for (int a = 0; a < 4; a++) stage(4'(a), 18'($urandom));
      if ($urandom_range(0, 1) == 1) stage(4'(3 + 4 * $urandom_range(0, 3)), 18'($urandom));
   endtask

   task automatic drive_cmd(input bit ld, input bit up, input bit inj, input int len);
      load = ld; upd = up;
      @(negedge clk);
      load = 1'b0; upd = 1'b0;
      for (int k = 1; k <= len; k++) begin
         for (int i = 0; i < 3; i++) cap[i][k] = obs(i);
         if (inj && k == 2) begin
            load = 1'b1; swr = 1'b1; adr = 4'd0; sdat = 18'h3FFFF;
         end
         if (inj && k == 3) begin
            load = 1'b0; swr = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic commit_model();
      for (int i = 0; i < 3; i++) mdat[i] = mstg[i][0];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs(i) !== 22'h0) begin
            failures++;
            $display("FAIL reset inst=%0d got=%h exp=%h", i, obs(i), 22'h0);
         end
      end
   endtask

   task automatic test_spec_vector();
      logic [17:0] b1 [2];
      logic [17:0] b2 [2];
      stage(4'd2, 18'($urandom));
      stage(4'd3, 18'($urandom));
      stage(4'd0, 18'h1ABCD);
      stage(4'd1, 18'h00123);
      drive_cmd(1'b1, 1'b0, 1'b0, 20);
      b1[0] = '0; b1[1] = '0; b2[0] = '0; b2[1] = '0;
      for (int k = 1; k <= 20; k++) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap[i][k] !== exp_load(i, k)) begin
               failures++;
               $display("FAIL spec_load inst=%0d k=%0d got=%h exp=%h", i, k, cap[i][k],
                        exp_load(i, k));
            end
         end
         // Filter-side cascade: newest word enters the low DSP
         if (cap[0][k][19]) begin
            b1[1] = b1[0];
            b1[0] = cap[0][k][17:0];
         end
         if (cap[0][k][18]) begin
            b2[0] = b1[0];
            b2[1] = b1[1];
         end
      end
      checks++;
      if (b2[0] !== 18'h1ABCD || b2[1] !== 18'h00123) begin
         failures++;
         $display("FAIL spec_b2 got=%h/%h exp=%h/%h", b2[0], b2[1], 18'h1ABCD, 18'h00123);
      end
      commit_model();
   endtask

   task automatic test_random_loads();
      for (int r = 0; r < 3; r++) begin
         stage_random();
         drive_cmd(1'b1, 1'b0, 1'b0, 20);
         for (int k = 1; k <= 20; k++) begin
            for (int i = 0; i < 3; i++) begin
               checks++;
               if (cap[i][k] !== exp_load(i, k)) begin
                  failures++;
                  $display("FAIL rand_load r=%0d inst=%0d k=%0d got=%h exp=%h", r, i, k,
                           cap[i][k], exp_load(i, k));
               end
            end
         end
         commit_model();
      end
   endtask

   task automatic test_update();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drive_cmd(1'b0, 1'b1, 1'b0, 5);
      for (int k = 1; k <= 5; k++) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap[i][k] !== exp_upd(i, k)) begin
               failures++;
               $display("FAIL update inst=%0d k=%0d got=%h exp=%h", i, k, cap[i][k],
                        exp_upd(i, k));
            end
         end
      end
   endtask

   task automatic test_busy_ignore();
      stage_random();
      drive_cmd(1'b1, 1'b0, 1'b1, 20);
      for (int k = 1; k <= 20; k++) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap[i][k] !== exp_load(i, k)) begin
               failures++;
               $display("FAIL busy_ignore inst=%0d k=%0d got=%h exp=%h", i, k, cap[i][k],
                        exp_load(i, k));
            end
         end
      end
      drive_cmd(1'b1, 1'b0, 1'b0, 20);
      for (int k = 1; k <= 20; k++) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap[i][k] !== exp_load(i, k)) begin
               failures++;
               $display("FAIL busy_replay inst=%0d k=%0d got=%h exp=%h", i, k, cap[i][k],
                        exp_load(i, k));
            end
         end
      end
      commit_model();
   endtask

   task automatic test_reset_mid();
      stage_random();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs(i) !== exp_load(i, 1)) begin
            failures++;
            $display("FAIL rstmid_first inst=%0d got=%h exp=%h", i, obs(i), exp_load(i, 1));
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== 22'h0) begin
               failures++;
               $display("FAIL rstmid_quiet inst=%0d c=%0d got=%h exp=%h", i, c, obs(i), 22'h0);
            end
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
         mdat[i] = '0;
         for (int a = 0; a < 16; a++) mstg[i][a] = '0;
      end
      drive_cmd(1'b1, 1'b0, 1'b0, 20);
      for (int k = 1; k <= 20; k++) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap[i][k] !== exp_load(i, k)) begin
               failures++;
               $display("FAIL rstmid_reload inst=%0d k=%0d got=%h exp=%h", i, k, cap[i][k],
                        exp_load(i, k));
            end
         end
      end
      commit_model();
   endtask

   task automatic test_load_and_update();
      int npulse;
      stage_random();
      drive_cmd(1'b1, 1'b1, 1'b0, 20);
      for (int k = 1; k <= 20; k++) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap[i][k] !== exp_load(i, k)) begin
               failures++;
               $display("FAIL load_upd inst=%0d k=%0d got=%h exp=%h", i, k, cap[i][k],
                        exp_load(i, k));
            end
         end
      end
      npulse = 0;
      for (int k = 1; k <= 20; k++) npulse += int'(cap[0][k][18]);
      checks++;
      if (npulse != 1) begin
         failures++;
         $display("FAIL load_upd_pulses got=%0d exp=%0d", npulse, 1);
      end
      commit_model();
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         mdat[i] = '0;
         for (int a = 0; a < 16; a++) mstg[i][a] = '0;
      end
      @(negedge clk);
      test_reset();
      test_spec_vector();
      test_random_loads();
      test_update();
      test_busy_ignore();
      test_update();
      test_reset_mid();
      test_load_and_update();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/biquad8_coeff_loader.md
Name: biquad8_coeff_loader

Overview:
- Drives the serial coefficient-load port of the biquad8 filter: coeff_dat, coeff_wr and coeff_update.
- The host writes coefficients into a local staging register file, then issues a single load command.
- The loader shifts the staged words out in reverse order (highest index first) into the filter's B-register cascade, respecting the filter's registered clock-enable timing.
- It then optionally commits the new coefficients with an update pulse.

Parameters:
- NCOEFF, 2, number of coefficient words per load. Equals the B-cascade depth per DSP chain. Legal range 1..16.
- WR_GAP, 1, idle cycles between consecutive coeff_wr_o pulses. Minimum 1.
- AUTO_UPDATE, 1, 1 = issue coeff_update_o automatically after the shift completes; 0 = only on update_i.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stage_adr_i  in  max(1,$clog2(NCOEFF))  staging register index
- stage_dat_i  in  18  coefficient word, Q format as consumed by the DSP B port
- stage_wr_i  in  1  write stage_dat_i to staging[stage_adr_i]
- load_i  in  1  start a shift sequence (single-cycle pulse)
- update_i  in  1  request a commit pulse (used when AUTO_UPDATE=0; also accepted when AUTO_UPDATE=1)
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse when a sequence ends
- coeff_dat_o  out  18  to filter coeff_dat_i
- coeff_wr_o  out  1  to filter coeff_wr_i
- coeff_update_o  out  1  to filter coeff_update_i

Behaviour:
- Reset (rst=1 at a clk edge): all staging words are 0, the FSM goes to IDLE, and every output is 0.
- Reset mid-sequence aborts the sequence. No coeff_update_o or done_o is issued. The filter keeps its previously committed (B2) coefficients; its B1 contents are undefined until the next full load.
- Staging: stage_wr_i in IDLE writes the word on that edge. stage_wr_i while busy_o=1 is ignored. Addresses >= NCOEFF are ignored.
- FSM states: IDLE, SHIFT, GAP, SETTLE, UPDATE.
- IDLE -> SHIFT on load_i. The index is initialised to NCOEFF-1.
- SHIFT, one cycle:
  - coeff_wr_o=1.
  - coeff_dat_o=staging[idx].
  - If idx=0, go to SETTLE; else go to GAP.
- GAP:
  - Lasts WR_GAP cycles with coeff_wr_o=0.
  - Then idx decrements and the FSM returns to SHIFT.
- Data hold rule: coeff_dat_o changes only in a SHIFT cycle and holds its value at least through the following cycle. This is required because the filter registers coeff_wr before using it as the B1 clock enable.
- SETTLE: 2 cycles with all strobes 0, so the last B1 load lands before any B2 commit.
  - AUTO_UPDATE=1: go to UPDATE.
  - AUTO_UPDATE=0: go to IDLE and pulse done_o.
- UPDATE, one cycle: coeff_update_o=1. Next state IDLE, with done_o pulsed in the first IDLE cycle.
- update_i in IDLE: go to UPDATE, i.e. a commit without a shift. update_i while busy is ignored; it is redundant when AUTO_UPDATE=1.
- busy_o=1 in every non-IDLE state.
- load_i while busy is ignored, not queued.
- load_i and update_i in the same IDLE cycle: load_i wins.
- coeff_dat_o keeps its last value while idle.
- Latency, NCOEFF=2, WR_GAP=1, AUTO_UPDATE=1, load_i sampled at edge T:
  - coeff_wr_o high at T+1 and T+3.
  - coeff_dat_o = staging[1] during T+1..T+2 and staging[0] from T+3.
  - coeff_update_o high at T+6.
  - busy_o high T+1..T+6.
  - done_o high at T+7.
- General timing:
  - Last write at T+1+(NCOEFF-1)(WR_GAP+1).
  - Update at last write + 3.
- Resulting filter contents: staging[0] sits in the first (low) DSP of each cascade pair and staging[NCOEFF-1] in the last.

Test Plan:
- Reset, then stage 0x1ABCD at index 0 and 0x00123 at index 1, then pulse load_i at T -> coeff_wr_o pulses at T+1 (dat 0x00123) and T+3 (dat 0x1ABCD); coeff_update_o at T+6; done_o at T+7; a biquad8 model shows B2 low=0x1ABCD and B2 high=0x00123.
- WR_GAP=3, NCOEFF=4 -> write pulses 4 cycles apart; dat held stable for 4 cycles per word; update 3 cycles after the 4th write.
- AUTO_UPDATE=0: load_i -> no coeff_update_o; done_o at last write + 3; a later update_i at U -> coeff_update_o at U+1 and done_o at U+2.
- Second load_i pulse and stage_wr_i (index 0, 0x3FFFF) during busy -> no extra write pulses; staging[0] unchanged; the next load replays the old value.
- rst asserted on the cycle after the first write -> all outputs 0 on the next cycle; no update or done; staging reads back as 0 on the next load.
- load_i and update_i asserted together in IDLE -> full shift sequence followed by exactly one coeff_update_o pulse.
